// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10-bit frame, ACK check.
// Optional macro PS2TX_CLK_FILTER_EN adds a FILTER_LEN-sample glitch filter on the PS/2 clock.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2400,
  parameter int TIMEOUT_CYC = 48000
`ifdef PS2TX_CLK_FILTER_EN
  , parameter int FILTER_LEN = 8
`endif
) (
  input  logic       clk_bus,
  input  logic       bus_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_stb,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAITREL
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shreg_q;
  logic             tx_busy_q;
  logic             tx_done_q;
  logic             tx_err_q;
  logic             clk_oe_q;
  logic             dat_oe_q;

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  logic       clk_s;
  logic       dat_s;
  logic       clk_lvl;
  logic       fe;

  // Synchronizers reset to the released (high) bus level so reset cannot fake an edge.
  always_ff @(posedge clk_bus) begin
    if (!bus_reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

`ifdef PS2TX_CLK_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          clk_filt_q;
  logic [FW-1:0] filt_cnt_q;

  // The filtered level follows the synced clock only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk_bus) begin
    if (!bus_reset_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s == clk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      clk_filt_q <= clk_s;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  assign clk_lvl = clk_filt_q;
`else
  assign clk_lvl = clk_s;
`endif

  always_ff @(posedge clk_bus) begin
    if (!bus_reset_n) clk_prev_q <= 1'b1;
    else              clk_prev_q <= clk_lvl;
  end

  assign fe = clk_prev_q & ~clk_lvl;

  always_ff @(posedge clk_bus) begin
    if (!bus_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_oe_q  <= 1'b0;
          dat_oe_q  <= 1'b0;
          tx_busy_q <= 1'b0;
          if (tx_stb) begin
            shreg_q   <= {1'b1, ~^tx_data, tx_data};
            cnt_q     <= '0;
            clk_oe_q  <= 1'b1;
            tx_busy_q <= 1'b1;
            state_q   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
            dat_oe_q  <= 1'b1;
            clk_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= S_SEND;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_SEND: begin
          if (fe) begin
            dat_oe_q  <= ~shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            cnt_q     <= '0;
            if (bit_cnt_q == 4'd9) state_q <= S_ACK;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            tx_err_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_ACK: begin
          if (fe) begin
            cnt_q <= '0;
            if (!dat_s) begin
              state_q <= S_WAITREL;
            end else begin
              tx_err_q  <= 1'b1;
              tx_busy_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            tx_err_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WAITREL: begin
          // Device must release both lines after its ACK before the transfer counts as done.
          if (clk_s && dat_s) begin
            tx_done_q <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (fe) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            tx_err_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          dat_oe_q  <= 1'b0;
          tx_busy_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a frame scoreboard.
module tb_ps2_host_tx;

  localparam int INH  = 2400;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk_bus;
  logic       bus_reset_n;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       dev_clk;
  logic       dev_dat;
  logic       clk_line;
  logic       dat_line;

  // Open-drain bus: a line is high only if neither side pulls it low.
  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_bus    (clk_bus),
    .bus_reset_n(bus_reset_n),
    .tx_data    (tx_data),
    .tx_stb     (tx_stb),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  typedef struct packed {
    logic [9:0] frame;
    logic       ack;
  } exp_t;

  exp_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int viol_cnt    = 0;

  always @(negedge clk_bus) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) viol_cnt++;
    if (!tx_busy && (ps2_clk_oe || ps2_dat_oe)) viol_cnt++;
    if (ps2_clk_oe && ps2_dat_oe) viol_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_bus);
  endtask

  // Requests a transfer, records the expected frame, and checks the inhibit phase.
  task automatic start_tx(input logic [7:0] d, input logic ack);
    exp_t e;
    int   n;
    e.frame = {1'b1, ~^d, d};
    e.ack   = ack;
    sb_q.push_back(e);
    tx_data = d;
    tx_stb  = 1'b1;
    @(negedge clk_bus);
    tx_stb = 1'b0;
    check("busy_on", 32'(tx_busy), 32'd1);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      @(negedge clk_bus);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("start_bit", 32'(ps2_dat_oe), 32'd1);
  endtask

  // Device clocks n falling edges, sampling the data line on each following rising edge.
  task automatic device_run(input int n, input logic ack_low, output logic [9:0] bits);
    bits = '0;
    tick(10);
    for (int k = 1; k <= n; k++) begin
      dev_clk = 1'b0;
      tick(HALF);
      if (k <= 10) bits[k-1] = dat_line;
      dev_clk = 1'b1;
      if (k == 10 && ack_low) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 200) begin
      n++;
      @(negedge clk_bus);
    end
    check("idle_reached", 32'(tx_busy), 32'd0);
  endtask

  // Full transfer outcome: frame on the wire and exactly one done or err pulse.
  task automatic finish_full(input string tag, input logic [9:0] bits, input int d0, input int e0);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_frame"}, 32'(bits), 32'(e.frame));
      wait_idle();
      check({tag, "_done_pulses"}, 32'(done_cnt - d0), e.ack ? 32'd1 : 32'd0);
      check({tag, "_err_pulses"}, 32'(err_cnt - e0), e.ack ? 32'd0 : 32'd1);
    end
  endtask

  logic [9:0] bits;
  int         d0, e0, n;
  exp_t       ep;

  initial begin
    bus_reset_n = 1'b0;
    tx_stb      = 1'b0;
    tx_data     = 8'h00;
    dev_clk     = 1'b1;
    dev_dat     = 1'b1;
    tick(5);
    check("reset_outputs", 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    bus_reset_n = 1'b1;
    tick(100);
    check("idle_outputs", 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("idle_pulses", 32'(done_cnt + err_cnt), 32'd0);

    // LED command with ACK
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED, 1'b1);
    device_run(11, 1'b1, bits);
    check("ed_data_bits", 32'(bits[7:0]), 32'hED);
    finish_full("ed", bits, d0, e0);
    $display("tx 0xED ack: bits=%03h done=%0d err=%0d", bits, done_cnt - d0, err_cnt - e0);

    // Parity extremes
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00, 1'b1);
    device_run(11, 1'b1, bits);
    check("par_00", 32'(bits[8]), 32'd1);
    finish_full("x00", bits, d0, e0);
    $display("tx 0x00 ack: bits=%03h", bits);

    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h01, 1'b1);
    device_run(11, 1'b1, bits);
    check("par_01", 32'(bits[8]), 32'd0);
    finish_full("x01", bits, d0, e0);
    $display("tx 0x01 ack: bits=%03h", bits);

    // Device stalls after 5 falling edges: 2 sync flops + 1 registered response + TO idle cycles
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h3C, 1'b0);
    device_run(4, 1'b0, bits);
    ep = sb_q.pop_front();
    check("to_partial_frame", 32'(bits[3:0]), 32'(ep.frame[3:0]));
    dev_clk = 1'b0;
    n = 0;
    while (!tx_err && n < TO + 100) begin
      @(posedge clk_bus);
      #1;
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TO + 3));
    check("timeout_release", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    dev_clk = 1'b1;
    tick(10);
    check("timeout_busy", 32'(tx_busy), 32'd0);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_nodone", 32'(done_cnt - d0), 32'd0);
    $display("tx 0x3C timeout: latency=%0d err=%0d", n, err_cnt - e0);

    // No ACK, plus an ignored second request mid-transfer
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h5A, 1'b0);
    tx_data = 8'h55;
    tx_stb  = 1'b1;
    tick(1);
    tx_stb = 1'b0;
    device_run(11, 1'b0, bits);
    finish_full("nack", bits, d0, e0);
    tick(20);
    check("nack_no_requeue", 32'({tx_busy, ps2_clk_oe}), 32'd0);
    $display("tx 0x5A nack: bits=%03h err=%0d done=%0d", bits, err_cnt - e0, done_cnt - d0);

    // Reset mid-SEND while data is pulled low
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hA1, 1'b1);
    device_run(3, 1'b0, bits);
    ep = sb_q.pop_front();
    check("rst_partial_frame", 32'(bits[2:0]), 32'(ep.frame[2:0]));
    check("rst_dat_low_before", 32'(ps2_dat_oe), 32'd1);
    bus_reset_n = 1'b0;
    tick(1);
    check("rst_release", 32'({tx_busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    bus_reset_n = 1'b1;
    tick(20);
    check("rst_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("rst_idle", 32'(tx_busy), 32'd0);
    $display("tx 0xA1 reset: busy=%0d pulses=%0d", tx_busy, (done_cnt - d0) + (err_cnt - e0));

`ifdef PS2TX_CLK_FILTER_EN
    // A short low glitch on the clock must not shift a bit out
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h0F, 1'b1);
    tick(10);
    dev_clk = 1'b0;
    tick(3);
    dev_clk = 1'b1;
    tick(30);
    check("glitch_no_shift", 32'(ps2_dat_oe), 32'd1);
    device_run(11, 1'b1, bits);
    finish_full("glitch", bits, d0, e0);
    $display("tx 0x0F glitch: bits=%03h", bits);
`endif

    check("invariants", 32'(viol_cnt), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
